// File: rtl/clk_en_pkg.sv
// Shared constants for the clock-enable generator: channel map and default divisors.
package clk_en_pkg;

   localparam int DEF_CNT_W = 16;

   typedef enum logic [1:0] {
      CH_SPI   = 2'd0,
      CH_AUDIO = 2'd1,
      CH_PIXEL = 2'd2
   } ch_e;

   localparam int SPI_DIV   = 40;
   localparam int AUDIO_DIV = 5000;
   localparam int PIXEL_DIV = 4;

endpackage

// File: rtl/clk_en_chan.sv
// One enable channel: up-counter, active/pending divisor, boundary apply and resync.
// Optional CLK_EN_PHASE_EN adds a per-channel resync phase.
module clk_en_chan #(
   parameter int               CNT_W = 16,
   parameter logic [CNT_W-1:0] DEF   = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_run,
   input  logic             i_resync,
   input  logic             i_wr,
   input  logic [CNT_W-1:0] i_div,
`ifdef CLK_EN_PHASE_EN
   input  logic [CNT_W-1:0] i_phase,
`endif
   output logic             o_pend_v,
   output logic             o_en
);

   logic [CNT_W-1:0] r_cnt, r_div, r_pend;
   logic             r_pend_v, r_en;
   logic [CNT_W-1:0] w_term, w_new_div, w_new_term, w_load;
   logic             w_tc;

   // Divisors 0 and 1 both collapse to a terminal count of 0 (enable every cycle).
   assign w_term     = (r_div > CNT_W'(1)) ? r_div - CNT_W'(1) : '0;
   assign w_new_div  = r_pend_v ? r_pend : r_div;
   assign w_new_term = (w_new_div > CNT_W'(1)) ? w_new_div - CNT_W'(1) : '0;
   assign w_tc       = (r_cnt == w_term);

`ifdef CLK_EN_PHASE_EN
   logic [CNT_W-1:0] r_phase;

   always_ff @(posedge i_clk) begin
      if (i_rst)     r_phase <= '0;
      else if (i_wr) r_phase <= i_phase;
   end

   assign w_load = (r_phase < w_new_term) ? r_phase : w_new_term;
`else
   assign w_load = '0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt    <= '0;
         r_div    <= DEF;
         r_pend   <= '0;
         r_pend_v <= 1'b0;
         r_en     <= 1'b0;
      end else begin
         if (i_resync) begin
            r_cnt    <= w_load;
            r_div    <= w_new_div;
            r_pend_v <= 1'b0;
            r_en     <= 1'b0;
         end else if (i_run) begin
            r_en <= w_tc;
            if (w_tc) begin
               r_cnt <= '0;
               if (r_pend_v) begin
                  r_div    <= r_pend;
                  r_pend_v <= 1'b0;
               end
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end else begin
            r_en <= 1'b0;
         end
         // Accept never coincides with apply: the top only writes when pend_v is low.
         if (i_wr) begin
            r_pend   <= i_div;
            r_pend_v <= 1'b1;
         end
      end
   end

   assign o_pend_v = r_pend_v;
   assign o_en     = r_en;

endmodule

// File: rtl/clk_en_gen_multi.sv
// N-channel clock-enable generator with runtime divisors and global resync.
// Optional CLK_EN_PHASE_EN adds cfg_phase for staggered resync.
module clk_en_gen_multi
   import clk_en_pkg::*;
#(
   parameter int                      NUM_CH  = 3,
   parameter int                      CNT_W   = DEF_CNT_W,
   parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV = {16'(PIXEL_DIV), 16'(AUDIO_DIV), 16'(SPI_DIV)},
   parameter int                      CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              CLK_40,
   input  logic              reset,
   input  logic              run,
   input  logic              resync,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
`ifdef CLK_EN_PHASE_EN
   input  logic [CNT_W-1:0]  cfg_phase,
`endif
   output logic              cfg_err,
   output logic [NUM_CH-1:0] clk_en
);

   localparam int SEL_N = 1 << CH_W;

   logic [NUM_CH-1:0] w_pend_v, w_wr;
   logic [SEL_N-1:0]  w_pv_ext;
   logic              w_oor;
   logic              r_err;

   // Unused select codes read as "not pending", so out-of-range writes are always ready.
   always_comb begin
      w_pv_ext               = '0;
      w_pv_ext[NUM_CH-1:0]   = w_pend_v;
   end

   assign w_oor     = ({1'b0, cfg_ch} >= (CH_W+1)'(NUM_CH));
   assign cfg_ready = ~w_pv_ext[cfg_ch];

   always_ff @(posedge CLK_40) begin
      if (reset) r_err <= 1'b0;
      else       r_err <= cfg_valid & w_oor;
   end

   assign cfg_err = r_err;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_wr[gi] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(gi));

      clk_en_chan #(
         .CNT_W (CNT_W),
         .DEF   (DEF_DIV[gi*CNT_W +: CNT_W])
      ) u_chan (
         .i_clk    (CLK_40),
         .i_rst    (reset),
         .i_run    (run),
         .i_resync (resync),
         .i_wr     (w_wr[gi]),
         .i_div    (cfg_div),
`ifdef CLK_EN_PHASE_EN
         .i_phase  (cfg_phase),
`endif
         .o_pend_v (w_pend_v[gi]),
         .o_en     (clk_en[gi])
      );
   end

endmodule

// File: tb/tb_clk_en_gen_multi.sv
// Self-checking bench for clk_en_gen_multi: hand tables/sequences plus a countdown reference model.
module tb_clk_en_gen_multi;
   import clk_en_pkg::*;

   localparam int NCH = 3;

   logic        CLK_40 = 1'b0;
   logic        reset = 1'b1, run = 1'b0, resync = 1'b0, cfg_valid = 1'b0;
   logic [1:0]  cfg_ch = '0;
   logic [15:0] cfg_div = '0;
   logic        cfg_ready, cfg_err;
   logic [2:0]  clk_en;

   always #5 CLK_40 = ~CLK_40;

   clk_en_gen_multi dut (
      .CLK_40    (CLK_40),
      .reset     (reset),
      .run       (run),
      .resync    (resync),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_err   (cfg_err),
      .clk_en    (clk_en)
   );

   int checks = 0, errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Reference model: each channel counts down the cycles left until its next pulse.
   int       def_div[NCH] = '{SPI_DIV, AUDIO_DIV, PIXEL_DIV};
   int       m_div[NCH], m_pend[NCH], m_left[NCH];
   bit       m_pv[NCH];
   bit [2:0] m_en;
   bit       m_err;

   function automatic int eff(input int d);
      return (d < 1) ? 1 : d;
   endfunction

   function automatic void model_step();
      int c;
      bit acc;
      c = int'(cfg_ch);
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            m_div[i] = def_div[i]; m_pv[i] = 0; m_left[i] = eff(def_div[i]);
         end
         m_en = '0; m_err = 0;
         return;
      end
      acc   = cfg_valid && (c < NCH) && !m_pv[c];
      m_err = cfg_valid && (c >= NCH);
      for (int i = 0; i < NCH; i++) begin
         if (resync) begin
            if (m_pv[i]) begin m_div[i] = m_pend[i]; m_pv[i] = 0; end
            m_left[i] = eff(m_div[i]);
            m_en[i]   = 0;
         end else if (run) begin
            m_left[i]--;
            m_en[i] = (m_left[i] == 0);
            if (m_left[i] == 0) begin
               if (m_pv[i]) begin m_div[i] = m_pend[i]; m_pv[i] = 0; end
               m_left[i] = eff(m_div[i]);
            end
         end else begin
            m_en[i] = 0;
         end
      end
      if (acc) begin m_pend[c] = int'(cfg_div); m_pv[c] = 1; end
   endfunction

   task automatic tick();
      int c;
      #2;
      c = int'(cfg_ch);
      chk("model_ready", cfg_ready, (c >= NCH) ? 1'b1 : !m_pv[c]);
      @(posedge CLK_40);
      model_step();
      #1;
      chk("model_clk_en", clk_en, m_en);
      chk("model_cfg_err", cfg_err, m_err);
   endtask

   task automatic do_reset();
      reset = 1; run = 0; resync = 0; cfg_valid = 0;
      repeat (3) tick();
      reset = 0;
   endtask

   task automatic cfg_write(input int ch, input int div);
      cfg_valid = 1; cfg_ch = 2'(ch); cfg_div = 16'(div);
      tick();
      cfg_valid = 0;
   endtask

   // First/second pulse tick (1-based, -1 if none) and pulse count per channel over n ticks.
   int fp[NCH], sp[NCH], pc[NCH];
   task automatic run_window(input int n);
      for (int i = 0; i < NCH; i++) begin fp[i] = -1; sp[i] = -1; pc[i] = 0; end
      for (int k = 1; k <= n; k++) begin
         tick();
         for (int i = 0; i < NCH; i++) if (clk_en[i]) begin
            pc[i]++;
            if (fp[i] < 0) fp[i] = k;
            else if (sp[i] < 0) sp[i] = k;
         end
      end
   endtask

   typedef struct {
      bit         vld;
      logic [1:0] ch;
      logic [15:0] div;
      bit         rdy;
      bit         err;
   } vec_t;
   vec_t tbl[11];

   initial begin
      tbl[0]  = '{0, 2'd0, 16'd0,  1, 0};
      tbl[1]  = '{1, 2'd0, 16'd20, 1, 0};
      tbl[2]  = '{1, 2'd0, 16'd30, 0, 0};
      tbl[3]  = '{1, 2'd3, 16'd9,  1, 1};
      tbl[4]  = '{0, 2'd3, 16'd0,  1, 0};
      tbl[5]  = '{1, 2'd1, 16'd7,  1, 0};
      tbl[6]  = '{0, 2'd1, 16'd0,  0, 0};
      tbl[7]  = '{0, 2'd2, 16'd0,  1, 0};
      tbl[8]  = '{1, 2'd3, 16'd9,  1, 1};
      tbl[9]  = '{1, 2'd3, 16'd5,  1, 1};
      tbl[10] = '{0, 2'd0, 16'd0,  0, 0};

      // Defaults after reset release.
      do_reset();
      chk("rst_clk_en", clk_en, 0);
      chk("rst_cfg_err", cfg_err, 0);
      run = 1;
      run_window(5000);
      chk("def_first_ch0", fp[0], 40);
      chk("def_second_ch0", sp[0], 80);
      chk("def_first_ch1", fp[1], 5000);
      chk("def_first_ch2", fp[2], 4);
      chk("def_second_ch2", sp[2], 8);

      // Divisor change mid-period on channel 0.
      do_reset();
      run = 1;
      repeat (10) tick();
      cfg_write(0, 20);
      cfg_ch = 2'd0;
      chk("hold_off_ready", cfg_ready, 0);
      run_window(70);
      chk("chg_first_ch0", fp[0], 29);
      chk("chg_second_ch0", sp[0], 49);
      chk("chg_count_ch0", pc[0], 3);
      chk("chg_ready_after", cfg_ready, 1);

      // Divisors 0 and 1 give an every-cycle enable; run=0 freezes.
      cfg_write(2, 0);
      repeat (6) tick();
      run_window(5);
      chk("div0_every_cycle", pc[2], 5);
      cfg_write(2, 1);
      repeat (6) tick();
      run_window(5);
      chk("div1_every_cycle", pc[2], 5);
      run = 0;
      run_window(4);
      chk("paused_pulses", pc[0] + pc[1] + pc[2], 0);
      run = 1;
      repeat (30) tick();

      // Resync applies a pending divisor immediately.
      cfg_write(0, 8);
      tick();
      resync = 1;
      tick();
      chk("resync_clk_en", clk_en, 0);
      resync = 0;
      run_window(20);
      chk("resync_first_ch0", fp[0], 8);
      chk("resync_second_ch0", sp[0], 16);
      chk("resync_first_ch2", fp[2], 1);

      // Table: config decode with counters paused.
      do_reset();
      run = 0;
      foreach (tbl[r]) begin
         cfg_valid = tbl[r].vld; cfg_ch = tbl[r].ch; cfg_div = tbl[r].div;
         #1;
         chk($sformatf("tbl%0d_ready", r), cfg_ready, tbl[r].rdy);
         tick();
         chk($sformatf("tbl%0d_err", r), cfg_err, tbl[r].err);
         chk($sformatf("tbl%0d_en", r), clk_en, 0);
      end
      cfg_valid = 0;
      run = 1; resync = 1;
      tick();
      resync = 0;
      run_window(25);
      chk("tbl_first_ch0", fp[0], 20);
      chk("tbl_first_ch1", fp[1], 7);
      chk("tbl_first_ch2", fp[2], 4);

      // Reset mid-period discards the new divisor and pending writes.
      cfg_write(0, 12);
      repeat (3) tick();
      cfg_write(1, 3);
      reset = 1;
      repeat (3) begin
         tick();
         chk("in_reset_clk_en", clk_en, 0);
      end
      reset = 0;
      cfg_ch = 2'd1;
      #1;
      chk("post_rst_ready_ch1", cfg_ready, 1);
      run_window(45);
      chk("post_rst_first_ch0", fp[0], 40);
      chk("post_rst_first_ch2", fp[2], 4);
      chk("post_rst_count_ch1", pc[1], 0);

      // Randomized traffic against the model.
      do_reset();
      for (int k = 0; k < 4000; k++) begin
         reset     = ($urandom_range(0, 799) == 0);
         run       = ($urandom_range(0, 7) != 0);
         resync    = ($urandom_range(0, 96) == 0);
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_ch    = 2'($urandom_range(0, 3));
         cfg_div   = 16'($urandom_range(0, 11));
         tick();
      end
      reset = 0; run = 0; resync = 0; cfg_valid = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clk_en_gen_multi.md
Name: clk_en_gen_multi

Overview:
Parametrised N-channel clock-enable generator. It replaces the fixed SPI and audio dividers with per-channel divisors that can be changed at runtime. Each channel emits a one-cycle enable pulse every DIV cycles of CLK_40. New divisors are applied glitch-free at period boundaries, and a global resync realigns all channels. Sits at the top level and feeds the SPI reader, audio DAC and pixel pipeline.

Parameters:
NUM_CH, 3, number of enable channels (1..16)
CNT_W, 16, counter/divisor width in bits
DEF_DIV, {16'd4, 16'd5000, 16'd40}, packed NUM_CH*CNT_W reset divisors; channel i is DEF_DIV[i*CNT_W +: CNT_W]
CH_W, $clog2(NUM_CH) min 1, channel-select width

Ports:
CLK_40  in  1  system clock; sole clock
reset  in  1  synchronous, active-high
run  in  1  counters advance only while high
resync  in  1  one-cycle pulse; realign all channels
cfg_valid  in  1  divisor write request
cfg_ready  out  1  combinational; high when the addressed channel has no pending divisor
cfg_ch  in  CH_W  target channel
cfg_div  in  CNT_W  new divisor
cfg_err  out  1  registered one-cycle pulse; write to a channel >= NUM_CH
clk_en  out  NUM_CH  per-channel enable pulses

Behaviour:
- Reset:
  - cnt[i]=0, div_act[i]=DEF_DIV[i], pend_v[i]=0.
  - clk_en=0, cfg_err=0.
  - reset overrides all other inputs.
- Effective divisor: eff=max(div_act,1). A divisor of 0 or 1 means the enable is high every running cycle.
- Running (run=1, no resync):
  - cnt[i] increments.
  - At cnt[i]==eff-1, cnt[i]<=0.
  - clk_en[i] is registered: high in the cycle after the terminal count.
  - First pulse arrives eff cycles after the first running cycle; period is exactly eff cycles.
- run=0:
  - cnt holds its value; clk_en=0.
  - Pending divisors are not applied.
  - On resuming, counting continues from the held value.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - cfg_ready = !pend_v[cfg_ch]; it is 1 for an out-of-range cfg_ch.
  - An accepted in-range write sets pend[cfg_ch]=cfg_div and pend_v=1.
  - An out-of-range write is dropped and cfg_err pulses the next cycle.
- Apply rule:
  - When run && cnt[i]==eff-1 && pend_v[i]: div_act[i]<=pend[i], pend_v[i]<=0, cnt<=0.
  - The clk_en pulse for that boundary still fires.
  - The next period uses the new divisor.
  - There is never a short or double pulse.
- resync (priority below reset, above everything else):
  - All cnt<=0 (or phase, see optional feature).
  - All pending divisors are applied immediately.
  - clk_en<=0 that cycle.
  - The next pulse arrives eff cycles after the first running cycle following resync.
- Simultaneous cfg accept and apply on the same channel cannot occur, because cfg_ready is low while pending.
- cfg to channel A while channel B applies: both proceed independently.
- Reset mid-period: divisors revert to DEF_DIV and pending writes are lost.
- Arithmetic is unsigned CNT_W-bit; eff-1 is computed once per channel, with no wrap because eff>=1.

Optional Feature:
CLK_EN_PHASE_EN
- With the macro defined:
  - Adds input cfg_phase [CNT_W] and a per-channel phase register (reset 0).
  - cfg_phase is written alongside cfg_div in the same handshake.
  - On resync, cnt[i]<=min(phase[i], eff-1), so channels can be staggered.
  - A phase equal to eff-1 yields a pulse on the second running cycle.
- Without the macro: no cfg_phase port, and resync always loads 0.

Decomposition:
- Package clk_en_pkg:
  - Channel indices CH_SPI=0, CH_AUDIO=1, CH_PIXEL=2.
  - Default divisors SPI_DIV=40, AUDIO_DIV=5000, PIXEL_DIV=4.
  - CNT_W default.
- One sub-module, clk_en_chan: one counter, active and pending divisor, apply/resync logic and registered enable.
  - Instantiated NUM_CH times in a generate loop.
  - The top level holds the cfg decode, cfg_ready mux and cfg_err.

Test Plan:
1. Reset, run=1 with defaults → clk_en[0] period 40, clk_en[1] period 5000, clk_en[2] period 4; first pulses at cycles 40/5000/4 after reset release.
2. Channel 0 at cnt=10: write div=20 → cfg_ready low until the boundary; pulse at the old period (cycle 40), then every 20; no extra pulse.
3. Write div=0 and then div=1 to channel 2 → clk_en[2] high every cycle; run=0 → clk_en all 0 and counters frozen; run=1 → resume from the held count.
4. resync at an arbitrary cycle with a pending div=8 on channel 0 → clk_en=0 that cycle; channel 0 pulses 8 cycles after resync; channels 1 and 2 realigned to count from 0.
5. cfg_ch=3 with NUM_CH=3 → cfg_ready=1, cfg_err pulses once, no channel changes; second write to a pending channel is held off until apply.
6. Reset asserted mid-period after a div change → divisors return to 40/5000/4, pending cleared, clk_en=0 while reset is high.
